// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit words, byte strobes, OKAY/SLVERR, flat regs_o export.
// Latency: B one cycle after the last AW/W handshake; R one cycle after the AR handshake.
// Backpressure: one outstanding write and one outstanding read; B/R are held stable until bready/rready.
module axi4_lite_slave_regs #(
    parameter int AXI_WIDTH = 32,
    parameter int AXI_DEPTH = 32,
    parameter int NUM_REGS  = 8
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DEPTH-1:0]          s_axi_awaddr,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    input  logic [AXI_WIDTH-1:0]          s_axi_wdata,
    input  logic [AXI_WIDTH/8-1:0]        s_axi_wstrb,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    input  logic [AXI_DEPTH-1:0]          s_axi_araddr,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [AXI_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic [NUM_REGS*AXI_WIDTH-1:0] regs_o
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = AXI_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_out_en;
    logic [AXI_DEPTH-1:0]  r_awaddr;
    logic [AXI_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [AXI_WIDTH-1:0]  r_rdata;
    logic [1:0]            r_rresp;
    logic [AXI_WIDTH-1:0]  r_regs [NUM_REGS];

    logic                  w_awready, w_wready, w_arready;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [AXI_DEPTH-1:0]  w_waddr;
    logic [AXI_WIDTH-1:0]  w_wdata_eff;
    logic [STRB_W-1:0]     w_wstrb_eff;
    logic [IDX_W-1:0]      w_widx, w_ridx;
    logic                  w_wok, w_rok;
    logic                  w_unused_addr_lsbs;

    // Readies are held low until the first edge after reset release, then decoded from state.
    assign w_awready = r_out_en & ((r_wstate == W_IDLE) | (r_wstate == W_HAVE_W));
    assign w_wready  = r_out_en & ((r_wstate == W_IDLE) | (r_wstate == W_HAVE_AW));
    assign w_arready = r_out_en & (r_rstate == R_IDLE);

    assign w_aw_hs = s_axi_awvalid & w_awready;
    assign w_w_hs  = s_axi_wvalid  & w_wready;
    assign w_ar_hs = s_axi_arvalid & w_arready;

    // Use the latched half of a split write, the live bus otherwise.
    assign w_waddr     = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axi_awaddr;
    assign w_wdata_eff = (r_wstate == W_HAVE_W)  ? r_wdata  : s_axi_wdata;
    assign w_wstrb_eff = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_axi_wstrb;

    assign w_widx = w_waddr[2 +: IDX_W];
    assign w_wok  = (w_waddr[AXI_DEPTH-1:2+IDX_W] == '0);
    assign w_ridx = s_axi_araddr[2 +: IDX_W];
    assign w_rok  = (s_axi_araddr[AXI_DEPTH-1:2+IDX_W] == '0);

    assign w_commit = (r_wstate != W_RESP) & (w_wstate_nxt == W_RESP);

    // Byte-lane address bits carry no meaning for word registers.
    assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], r_awaddr[1:0]};

    // Write channel next-state: AW and W may arrive together or in either order.
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
                else if (w_aw_hs)      w_wstate_nxt = W_HAVE_AW;
                else if (w_w_hs)       w_wstate_nxt = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)       w_wstate_nxt = W_RESP;
            W_HAVE_W:  if (w_aw_hs)      w_wstate_nxt = W_RESP;
            W_RESP:    if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default:   w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read channel next-state: one outstanding read.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
            R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Ready enable comes up one edge after reset release.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_out_en <= 1'b0;
        else                r_out_en <= 1'b1;
    end

    // Write state, latched AW/W halves and registered B response.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_bvalid <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) r_bresp <= w_wok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register file: byte-wise update on the edge that completes a valid write.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (w_commit && w_wok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wstrb_eff[b]) r_regs[w_widx][8*b +: 8] <= w_wdata_eff[8*b +: 8];
            end
        end
    end

    // Read state and captured data; a same-edge write is not yet visible here.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rvalid <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rdata <= w_rok ? r_regs[w_ridx] : '0;
                r_rresp <= w_rok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_arready = w_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*AXI_WIDTH +: AXI_WIDTH] = r_regs[k];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with a response scoreboard.
// Stimulus pushes expected B/R responses; a negedge monitor pops them on each handshake.
// Timing, backpressure and reset behaviour are checked inline by the stimulus.
module tb_axi4_lite_slave_regs;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] regs_o;

    int           total = 0;
    int           bad   = 0;
    logic [1:0]   exp_b[$];
    rexp_t        exp_r[$];
    logic [31:0]  mdl[8];
    logic [1:0]   mon_b;
    rexp_t        mon_r;

    axi4_lite_slave_regs #(.AXI_WIDTH(32), .AXI_DEPTH(32), .NUM_REGS(8)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s regs_o[%0d]", name, k), regs_o[k*32 +: 32], mdl[k]);
    endtask

    // Scoreboard monitor: compare every B/R handshake with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got bresp %0d expected no response", bresp);
                end else begin
                    mon_b = exp_b.pop_front();
                    chk("bresp", {30'd0, bresp}, {30'd0, mon_b});
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    total++; bad++;
                    $display("FAIL r_unexpected: got rdata 0x%08h expected no response", rdata);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("rdata", rdata, mon_r.d);
                    chk("rresp", {30'd0, rresp}, {30'd0, mon_r.r});
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] resp, input string name);
        int   n;
        logic aw_done, w_done;
        exp_b.push_back(resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(posedge clk); #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
            n++;
        end
        if (!(aw_done && w_done)) begin
            total++; bad++;
            $display("FAIL %s timeout: got no AW/W accept expected accept within 20 cycles", name);
            awvalid = 1'b0; wvalid = 1'b0;
            void'(exp_b.pop_back());
            return;
        end
        @(negedge clk); chk({name, " bvalid next cycle"}, {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk({name, " bvalid one cycle"}, {31'd0, bvalid}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] resp,
                           input string name);
        int    n;
        logic  done;
        rexp_t e;
        e.d = d; e.r = resp;
        exp_r.push_back(e);
        araddr = addr; arvalid = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (arready) done = 1'b1;
            @(posedge clk); #1;
            if (done) arvalid = 1'b0;
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout: got no AR accept expected accept within 20 cycles", name);
            arvalid = 1'b0;
            void'(exp_r.pop_back());
            return;
        end
        @(negedge clk); chk({name, " rvalid next cycle"}, {31'd0, rvalid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk({name, " rvalid one cycle"}, {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        for (int k = 0; k < 8; k++) mdl[k] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst awready", {31'd0, awready}, 32'd0);
        chk("rst wready",  {31'd0, wready},  32'd0);
        chk("rst arready", {31'd0, arready}, 32'd0);
        chk("rst bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst rdata",   rdata, 32'd0);
        chk_regs("rst");
        #2 rst_n = 1'b1;
        #1 chk("awready before first edge", {31'd0, awready}, 32'd0);
        @(posedge clk); #1;
        chk("awready after release", {31'd0, awready}, 32'd1);
        chk("wready after release",  {31'd0, wready},  32'd1);
        chk("arready after release", {31'd0, arready}, 32'd1);

        // Basic write and read
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00, "wr basic");
        mdl[2] = 32'hDEADBEEF;
        chk("regs_o[95:64]", regs_o[95:64], 32'hDEADBEEF);
        do_read(32'h08, 32'hDEADBEEF, 2'b00, "rd basic");

        // AW at cycle 0, W at cycle 3
        awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF;
        exp_b.push_back(2'b00);
        awvalid = 1'b1;
        @(negedge clk); chk("split aw awready c0", {31'd0, awready}, 32'd1);
        @(posedge clk); #1; awvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) wvalid = 1'b1;
            @(negedge clk);
            chk($sformatf("split aw awready c%0d", c), {31'd0, awready}, 32'd0);
            chk($sformatf("split aw wready c%0d", c),  {31'd0, wready},  32'd1);
            chk($sformatf("split aw bvalid c%0d", c),  {31'd0, bvalid},  32'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        @(negedge clk); chk("split aw bvalid c4", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        mdl[3] = 32'h12345678;

        // W at cycle 0, AW at cycle 3
        awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        exp_b.push_back(2'b00);
        wvalid = 1'b1;
        @(negedge clk); chk("split w wready c0", {31'd0, wready}, 32'd1);
        @(posedge clk); #1; wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) awvalid = 1'b1;
            @(negedge clk);
            chk($sformatf("split w wready c%0d", c),  {31'd0, wready},  32'd0);
            chk($sformatf("split w awready c%0d", c), {31'd0, awready}, 32'd1);
            chk($sformatf("split w bvalid c%0d", c),  {31'd0, bvalid},  32'd0);
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        @(negedge clk); chk("split w bvalid c4", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        mdl[4] = 32'hCAFEF00D;
        chk_regs("split");

        // Byte strobes
        do_write(32'h04, 32'h11223344, 4'hF, 2'b00, "wr strb full");
        do_write(32'h04, 32'hAABBCCDD, 4'b0101, 2'b00, "wr strb 0101");
        mdl[1] = 32'h11BB33DD;
        do_read(32'h04, 32'h11BB33DD, 2'b00, "rd strb");

        // Invalid addresses, and addr[1:0] ignored
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, 2'b10, "wr bad 0x20");
        do_write(32'h80000004, 32'hFFFFFFFF, 4'hF, 2'b10, "wr bad msb");
        chk_regs("after bad wr");
        do_read(32'h20, 32'h0, 2'b10, "rd bad 0x20");
        do_read(32'h0B, 32'hDEADBEEF, 2'b00, "rd 0x0B");

        // Backpressure: B and R held for 5 cycles
        bready = 1'b0; rready = 1'b0;
        exp_b.push_back(2'b00);
        exp_r.push_back('{d: 32'h12345678, r: 2'b00});
        awaddr = 32'h14; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        chk("bp readies", {29'd0, awready, wready, arready}, 32'd7);
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp bvalid %0d", c),  {31'd0, bvalid},  32'd1);
            chk($sformatf("bp bresp %0d", c),   {30'd0, bresp},   32'd0);
            chk($sformatf("bp rvalid %0d", c),  {31'd0, rvalid},  32'd1);
            chk($sformatf("bp rdata %0d", c),   rdata, 32'h12345678);
            chk($sformatf("bp rresp %0d", c),   {30'd0, rresp},   32'd0);
            chk($sformatf("bp awready %0d", c), {31'd0, awready}, 32'd0);
            chk($sformatf("bp arready %0d", c), {31'd0, arready}, 32'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("bp bvalid drop", {31'd0, bvalid}, 32'd0);
        chk("bp rvalid drop", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        mdl[5] = 32'h55;

        // Same-edge read and write of reg 2: read sees the old value
        exp_b.push_back(2'b00);
        exp_r.push_back('{d: 32'hDEADBEEF, r: 2'b00});
        awaddr = 32'h08; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        chk("collide readies", {29'd0, awready, wready, arready}, 32'd7);
        @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("collide bvalid", {31'd0, bvalid}, 32'd1);
        chk("collide rvalid", {31'd0, rvalid}, 32'd1);
        @(posedge clk); #1;
        mdl[2] = 32'h5;
        do_read(32'h08, 32'h5, 2'b00, "rd after collide");
        chk_regs("collide");

        // Reset while waiting for W
        awaddr = 32'h18; awvalid = 1'b1;
        @(posedge clk); #1; awvalid = 1'b0;
        @(negedge clk); chk("have_aw awready", {31'd0, awready}, 32'd0);
        #1 rst_n = 1'b0;
        for (int k = 0; k < 8; k++) mdl[k] = 32'h0;
        #1;
        chk("mid rst awready", {31'd0, awready}, 32'd0);
        chk("mid rst wready",  {31'd0, wready},  32'd0);
        chk("mid rst arready", {31'd0, arready}, 32'd0);
        chk("mid rst bvalid",  {31'd0, bvalid},  32'd0);
        chk("mid rst bresp",   {30'd0, bresp},   32'd0);
        chk_regs("mid rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post rst no bvalid %0d", c), {31'd0, bvalid}, 32'd0);
        end
        @(posedge clk); #1;
        do_write(32'h18, 32'h66, 4'hF, 2'b00, "wr post rst");
        mdl[6] = 32'h66;
        do_read(32'h18, 32'h66, 2'b00, "rd post rst");
        chk_regs("post rst");

        repeat (3) @(negedge clk);
        chk("b queue drained", 32'(exp_b.size()), 32'd0);
        chk("r queue drained", 32'(exp_r.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave register bank that sits directly downstream of the team's Wishbone-to-AXI4-Lite master and terminates its write and read transactions. It holds NUM_REGS control/status words, applies byte strobes on writes, returns OKAY or SLVERR responses, and exposes every register to fabric logic as a flat parallel bus. One outstanding write and one outstanding read are supported, and the two channels run independently.

## Interface
- AXI_WIDTH, 32: data width in bits; fixed at 32 (wstrb is 4 bits).
- AXI_DEPTH, 32: address width in bits.
- NUM_REGS, 8: number of 32-bit registers; power of 2, 2..256.
- s_axi_aclk  in  1  clock; all logic is on the rising edge.
- s_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- s_axi_awvalid / s_axi_awready  in / out  1 / 1  write address handshake.
- s_axi_awaddr  in  AXI_DEPTH  byte address.
- s_axi_wvalid / s_axi_wready  in / out  1 / 1  write data handshake.
- s_axi_wdata  in  AXI_WIDTH  write data.
- s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- s_axi_bvalid / s_axi_bready  out / in  1 / 1  write response handshake.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_arvalid / s_axi_arready  in / out  1 / 1  read address handshake.
- s_axi_araddr  in  AXI_DEPTH  byte address.
- s_axi_rvalid / s_axi_rready  out / in  1 / 1  read data handshake.
- s_axi_rdata  out  AXI_WIDTH  read data.
- s_axi_rresp  out  2  read response, same encoding as bresp.
- regs_o  out  NUM_REGS*AXI_WIDTH  register contents; register k is bits [32k+31:32k].

## Operation
- Address decode:
  - Word index is addr[2 +: log2(NUM_REGS)].
  - An address is valid when addr[AXI_DEPTH-1:2+log2(NUM_REGS)] == 0; addr[1:0] is ignored.
  - An invalid address gives SLVERR. An invalid write changes nothing. An invalid read returns rdata = 0.
- Write FSM states:
  - W_IDLE: awready = 1, wready = 1.
  - W_HAVE_AW: AW is latched and the FSM waits for W; awready = 0, wready = 1.
  - W_HAVE_W: W is latched and the FSM waits for AW; awready = 1, wready = 0.
  - W_RESP: bvalid = 1, awready = 0, wready = 0.
- Write transitions:
  - W_IDLE goes to W_HAVE_AW on an AW-only handshake, to W_HAVE_W on a W-only handshake, and to W_RESP when both handshake in the same cycle.
  - W_HAVE_AW or W_HAVE_W goes to W_RESP on the missing handshake.
  - W_RESP goes to W_IDLE on bvalid & bready.
- Write commit: on the edge that enters W_RESP, the addressed register is updated byte-wise. Byte i is written only when wstrb[i] = 1; other bytes keep their value. bresp is registered on that same edge.
- Read FSM states:
  - R_IDLE: arready = 1, rvalid = 0. An ar handshake registers rdata/rresp from the current register value and moves to R_DATA.
  - R_DATA: arready = 0, rvalid = 1. rdata and rresp hold steady until rready. rvalid & rready returns to R_IDLE.
- Channel independence: the write and read FSMs are fully independent.
  - A read and a write to the same register on the same edge: the read returns the value before the write.
- Reset (s_axi_aresetn low, asynchronous):
  - Both FSMs go to IDLE, every register clears to 0, and all latched address/data clears.
  - Outputs while in reset: awready = wready = arready = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, regs_o = 0.
  - Readies assert from the first clock edge after reset deasserts.
  - Reset asserted mid-transaction abandons it silently; no response is issued afterwards.
- Stable outputs: bvalid/bresp and rvalid/rdata/rresp stay stable while valid is high and ready is low.

## Timing
- Write latency: the last of the AW/W handshakes happens at edge N. At edge N the register updates and bvalid rises, so both are visible in the following cycle. With bready held high, bvalid lasts exactly 1 cycle.
- Write throughput: the next AW/W can be accepted in the cycle after the B handshake. Sustained rate is 1 write per 2 cycles.
- Read latency: an ar handshake at edge N makes rvalid high, with data, after edge N. Sustained rate is 1 read per 2 cycles.
- Address decode is combinational from the latched or live address. The only outputs not driven directly from flops are awready/wready/arready, which are decoded from FSM state.

## Test plan
- Basic write and read: AW and W together, addr 0x08, wdata 0xDEADBEEF, wstrb 4'hF -> bvalid 1 cycle later with bresp 00, regs_o[95:64] = 0xDEADBEEF. Then read 0x08 -> rvalid 1 cycle after ar, rdata 0xDEADBEEF, rresp 00.
- Split channels, both orders:
  - AW at cycle 0, W at cycle 3 -> awready 0 during cycles 1-3, bvalid in cycle 4.
  - W before AW -> same behaviour, with wready held low while waiting.
- Byte strobes: reg 1 = 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101 -> reg 1 reads 0x11BB33DD.
- Invalid address: write to 0x20 with NUM_REGS = 8 -> bresp 10 and no register changes. Read from 0x20 -> rresp 10, rdata 0.
- Backpressure and collision:
  - bready and rready held low for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable, and awready/arready stay 0.
  - Read of reg 2 and write 0x5 to reg 2 on the same edge -> read returns the old value; a following read returns 0x5.
- Reset: reset asserted while in W_HAVE_AW -> all outputs drop to their reset values immediately. After release, no B response appears, regs_o = 0, and a fresh write completes normally.
